// File: rtl/npu_load_pkg.sv
// Shared definitions for the row-memory load sequencer: FSM encoding,
// legal kernel sizes and the supported SRAM read-latency ceiling.
package npu_load_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [2:0] K1 = 3'd1;
  localparam logic [2:0] K3 = 3'd3;

  localparam int MAX_RD_LAT = 4;

  function automatic logic k_legal(input logic [2:0] k);
    return (k == K1) || (k == K3);
  endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Fixed-latency shift register that re-times a read's valid, index and pass
// so they line up with the SRAM's returned data.
module rd_lat_pipe #(
  parameter int LAT    = 1,
  parameter int IDX_W  = 11,
  parameter int PASS_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [PASS_W-1:0] in_pass,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx,
  output logic [PASS_W-1:0] out_pass
);

  logic [LAT-1:0]              vld_p;
  logic [LAT-1:0][IDX_W-1:0]   idx_p;
  logic [LAT-1:0][PASS_W-1:0]  pass_p;

  if (LAT == 1) begin : g_one
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_p[0]  <= 1'b0;
        pass_p[0] <= '0;
      end else begin
        vld_p[0]  <= in_valid;
        pass_p[0] <= in_pass;
      end
    end

    always_ff @(posedge clk) begin
      idx_p[0] <= in_idx;
    end
  end else begin : g_multi
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_p  <= '0;
        pass_p <= '0;
      end else begin
        vld_p  <= {vld_p[LAT-2:0], in_valid};
        pass_p <= {pass_p[LAT-2:0], in_pass};
      end
    end

    always_ff @(posedge clk) begin
      idx_p <= {idx_p[LAT-2:0], in_idx};
    end
  end

  assign out_valid = vld_p[LAT-1];
  assign out_idx   = idx_p[LAT-1];
  assign out_pass  = pass_p[LAT-1];

endmodule

// File: rtl/row_mem_load_sched.sv
// Row-memory load sequencer: streams activation/weight SRAM reads per IC pass.
// Define LOAD_PERF_CNT_EN to add saturating busy/stall cycle counters.
module row_mem_load_sched
  import npu_load_pkg::*;
#(
  parameter int INPUT_BW        = 8,
  parameter int ACT_PER_CORE    = 11,
  parameter int WEIGHT_PER_CORE = 9,
  parameter int ACT_SRAM_AW     = 13,
  parameter int WGT_SRAM_AW     = 11,
  parameter int SRAM_RD_LAT     = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [5:0]                        cfg_oc,
  input  logic [5:0]                        cfg_img_h,
  input  logic [5:0]                        cfg_img_w,
  input  logic [2:0]                        cfg_k,
  input  logic [1:0]                        cfg_num_pass,
  input  logic                              stall,
  output logic                              act_sram_en,
  output logic [ACT_SRAM_AW-1:0]            act_sram_addr,
  input  logic [INPUT_BW-1:0]               act_sram_rdata,
  output logic                              wgt_sram_en,
  output logic [WGT_SRAM_AW-1:0]            wgt_sram_addr,
  input  logic [INPUT_BW-1:0]               wgt_sram_rdata,
  output logic                              act_out_valid,
  output logic signed [INPUT_BW-1:0]        act_out_data,
  output logic [ACT_PER_CORE-1:0]           act_out_addr,
  output logic                              wgt_out_valid,
  output logic signed [INPUT_BW-1:0]        wgt_out_data,
  output logic [WEIGHT_PER_CORE-1:0]        wgt_out_addr,
  output logic [1:0]                        pass_idx,
  output logic                              busy,
  output logic                              done,
  output logic                              cfg_err
`ifdef LOAD_PERF_CNT_EN
  ,
  output logic [15:0]                       perf_busy_cycles,
  output logic [15:0]                       perf_stall_cycles
`endif
);

  localparam int DRAIN_W = $clog2(MAX_RD_LAT);
  localparam logic [12:0] ACT_MAX = 13'(1 << ACT_PER_CORE);
  localparam logic [10:0] WGT_MAX = 11'(1 << WEIGHT_PER_CORE);

  logic [2:0]             state_q;
  logic [5:0]             oc_q, h_q, w_q;
  logic [2:0]             k_q;
  logic [1:0]             np_q;
  logic [11:0]            act_n_q, act_idx_q;
  logic [9:0]             wgt_n_q, wgt_idx_q;
  logic [ACT_SRAM_AW-1:0] act_base_q;
  logic [WGT_SRAM_AW-1:0] wgt_base_q;
  logic [1:0]             pass_q;
  logic [DRAIN_W-1:0]     drain_q;
  logic                   cfg_err_q;

  logic [11:0] h_ext, w_ext, act_n_w;
  logic [9:0]  wgt_n_w;
  logic        cfg_bad;
  logic [2:0]  np_eff;
  logic        act_rd, wgt_rd, issue_done, more_pass;

  // Derived counts wrap at 12/10 bits by definition of the layer format.
  assign h_ext   = {6'd0, h_q} + {9'd0, k_q} - 12'd1;
  assign w_ext   = {6'd0, w_q} + {9'd0, k_q} - 12'd1;
  assign act_n_w = h_ext * w_ext;
  assign wgt_n_w = {7'd0, k_q} * {7'd0, k_q} * {4'd0, oc_q};
  assign cfg_bad = !k_legal(k_q) || ({1'b0, act_n_w} > ACT_MAX) ||
                   ({1'b0, wgt_n_w} > WGT_MAX) || (act_n_w == '0) || (wgt_n_w == '0);

  assign np_eff     = (np_q == 2'd0) ? 3'd1 : {1'b0, np_q};
  assign more_pass  = ({1'b0, pass_q} + 3'd1) < np_eff;
  assign act_rd     = (state_q == ST_ISSUE) && !stall && (act_idx_q < act_n_q);
  assign wgt_rd     = (state_q == ST_ISSUE) && !stall && (wgt_idx_q < wgt_n_q);
  assign issue_done = (act_idx_q >= act_n_q) && (wgt_idx_q >= wgt_n_q);

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && start) begin
      oc_q <= cfg_oc;
      h_q  <= cfg_img_h;
      w_q  <= cfg_img_w;
      k_q  <= cfg_k;
      np_q <= cfg_num_pass;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cfg_err_q  <= 1'b0;
      act_n_q    <= '0;
      wgt_n_q    <= '0;
      act_idx_q  <= '0;
      wgt_idx_q  <= '0;
      act_base_q <= '0;
      wgt_base_q <= '0;
      pass_q     <= '0;
      drain_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cfg_err_q <= 1'b0;
            state_q   <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          act_n_q    <= act_n_w;
          wgt_n_q    <= wgt_n_w;
          act_idx_q  <= '0;
          wgt_idx_q  <= '0;
          act_base_q <= '0;
          wgt_base_q <= '0;
          pass_q     <= '0;
          if (cfg_bad) begin
            cfg_err_q <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (act_rd) act_idx_q <= act_idx_q + 12'd1;
          if (wgt_rd) wgt_idx_q <= wgt_idx_q + 10'd1;
          if (issue_done) begin
            drain_q <= '0;
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_q == DRAIN_W'(SRAM_RD_LAT - 1)) begin
            if (more_pass) begin
              act_base_q <= act_base_q + ACT_SRAM_AW'(act_n_q);
              wgt_base_q <= wgt_base_q + WGT_SRAM_AW'(wgt_n_q);
              act_idx_q  <= '0;
              wgt_idx_q  <= '0;
              pass_q     <= pass_q + 2'd1;
              state_q    <= ST_ISSUE;
            end else begin
              state_q <= ST_DONE;
            end
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Read issue -> data return boundary (SRAM_RD_LAT stages)
  logic                       act_v_d, wgt_v_d;
  logic [ACT_PER_CORE-1:0]    act_idx_d;
  logic [WEIGHT_PER_CORE-1:0] wgt_idx_d;
  logic [1:0]                 act_pass_d, wgt_pass_d;

  rd_lat_pipe #(.LAT(SRAM_RD_LAT), .IDX_W(ACT_PER_CORE), .PASS_W(2)) u_act_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (act_rd),
    .in_idx    (act_idx_q[ACT_PER_CORE-1:0]),
    .in_pass   (pass_q),
    .out_valid (act_v_d),
    .out_idx   (act_idx_d),
    .out_pass  (act_pass_d)
  );

  rd_lat_pipe #(.LAT(SRAM_RD_LAT), .IDX_W(WEIGHT_PER_CORE), .PASS_W(2)) u_wgt_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (wgt_rd),
    .in_idx    (wgt_idx_q[WEIGHT_PER_CORE-1:0]),
    .in_pass   (pass_q),
    .out_valid (wgt_v_d),
    .out_idx   (wgt_idx_d),
    .out_pass  (wgt_pass_d)
  );

  // Reset forces every output low in the same cycle it is asserted.
  assign act_sram_en   = act_rd && !reset;
  assign act_sram_addr = act_sram_en ? (act_base_q + ACT_SRAM_AW'(act_idx_q)) : '0;
  assign wgt_sram_en   = wgt_rd && !reset;
  assign wgt_sram_addr = wgt_sram_en ? (wgt_base_q + WGT_SRAM_AW'(wgt_idx_q)) : '0;

  assign act_out_valid = act_v_d && !reset;
  assign act_out_addr  = act_out_valid ? act_idx_d : '0;
  assign act_out_data  = act_out_valid ? $signed(act_sram_rdata) : '0;
  assign wgt_out_valid = wgt_v_d && !reset;
  assign wgt_out_addr  = wgt_out_valid ? wgt_idx_d : '0;
  assign wgt_out_data  = wgt_out_valid ? $signed(wgt_sram_rdata) : '0;
  assign pass_idx      = reset ? 2'd0 : (act_v_d ? act_pass_d : wgt_pass_d);

  assign busy    = (state_q != ST_IDLE) && !reset;
  assign done    = (state_q == ST_DONE) && !reset;
  assign cfg_err = cfg_err_q && !reset;

`ifdef LOAD_PERF_CNT_EN
  logic [15:0] perf_busy_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (state_q != ST_IDLE && perf_busy_q != 16'hFFFF)
        perf_busy_q <= perf_busy_q + 16'd1;
      if (state_q == ST_ISSUE && stall && perf_stall_q != 16'hFFFF)
        perf_stall_q <= perf_stall_q + 16'd1;
    end
  end

  assign perf_busy_cycles  = reset ? '0 : perf_busy_q;
  assign perf_stall_cycles = reset ? '0 : perf_stall_q;
`endif

endmodule

// File: tb/tb_row_mem_load_sched.sv
// Directed bench for row_mem_load_sched: a timeline model of the read
// streams is checked against the DUT every cycle of each scenario.
module tb_row_mem_load_sched;

  localparam int LAT  = 1;
  localparam int MAXT = 1024;

  logic        clk = 1'b0;
  logic        reset, start, stall;
  logic [5:0]  cfg_oc, cfg_img_h, cfg_img_w;
  logic [2:0]  cfg_k;
  logic [1:0]  cfg_num_pass;
  logic        act_sram_en, wgt_sram_en;
  logic [12:0] act_sram_addr;
  logic [10:0] wgt_sram_addr;
  logic [7:0]  act_sram_rdata, wgt_sram_rdata;
  logic        act_out_valid, wgt_out_valid;
  logic [7:0]  act_out_data, wgt_out_data;
  logic [10:0] act_out_addr;
  logic [8:0]  wgt_out_addr;
  logic [1:0]  pass_idx;
  logic        busy, done, cfg_err;
`ifdef LOAD_PERF_CNT_EN
  logic [15:0] perf_busy_cycles, perf_stall_cycles;
`endif

  int n_chk = 0, n_fail = 0;
  int cyc = 0, t0_cyc = 0;
  bit chk_on = 1'b0;

  // Expected timeline, indexed by cycles since start was presented
  bit          e_aen [MAXT];
  logic [12:0] e_aaddr [MAXT];
  bit          e_wen [MAXT];
  logic [10:0] e_waddr [MAXT];
  bit          e_av [MAXT];
  logic [10:0] e_aidx [MAXT];
  bit          e_wv [MAXT];
  logic [8:0]  e_widx [MAXT];
  logic [1:0]  e_pass [MAXT];
  bit          e_busy [MAXT];
  bit          e_done [MAXT];
  bit          e_err [MAXT];
  int          e_len;

  row_mem_load_sched #(.SRAM_RD_LAT(LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cfg_oc         (cfg_oc),
    .cfg_img_h      (cfg_img_h),
    .cfg_img_w      (cfg_img_w),
    .cfg_k          (cfg_k),
    .cfg_num_pass   (cfg_num_pass),
    .stall          (stall),
    .act_sram_en    (act_sram_en),
    .act_sram_addr  (act_sram_addr),
    .act_sram_rdata (act_sram_rdata),
    .wgt_sram_en    (wgt_sram_en),
    .wgt_sram_addr  (wgt_sram_addr),
    .wgt_sram_rdata (wgt_sram_rdata),
    .act_out_valid  (act_out_valid),
    .act_out_data   (act_out_data),
    .act_out_addr   (act_out_addr),
    .wgt_out_valid  (wgt_out_valid),
    .wgt_out_data   (wgt_out_data),
    .wgt_out_addr   (wgt_out_addr),
    .pass_idx       (pass_idx),
    .busy           (busy),
    .done           (done),
`ifdef LOAD_PERF_CNT_EN
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] a_fn(input logic [12:0] a);
    return a[7:0] ^ {3'd0, a[12:8]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] w_fn(input logic [10:0] a);
    return a[7:0] ^ {5'd0, a[10:8]} ^ 8'hC3;
  endfunction

  // SRAM behaviour: data for an address appears LAT cycles after it is presented
  logic [12:0] a_d [LAT];
  logic [10:0] w_d [LAT];
  always @(posedge clk) begin
    a_d[0] <= act_sram_addr;
    w_d[0] <= wgt_sram_addr;
    for (int i = 1; i < LAT; i++) begin
      a_d[i] <= a_d[i-1];
      w_d[i] <= w_d[i-1];
    end
  end
  assign act_sram_rdata = a_fn(a_d[LAT-1]);
  assign wgt_sram_rdata = w_fn(w_d[LAT-1]);

  task automatic chk(input string nm, input int t, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", nm, t, got, exp);
    end
  endtask

  // Reads start two cycles after start; each pass ends with one idle ISSUE
  // cycle plus LAT drain cycles; done follows the final drain.
  task automatic build_model(input int oc, h, w, k, np, sf, sl, ra, input bit ep);
    int an, wn, npe, t, ai, wi, abase, wbase, dt;
    bit bad, stl;
    for (int i = 0; i < MAXT; i++) begin
      e_aen[i] = 0; e_aaddr[i] = '0; e_wen[i] = 0; e_waddr[i] = '0;
      e_av[i] = 0; e_aidx[i] = '0; e_wv[i] = 0; e_widx[i] = '0;
      e_pass[i] = '0; e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0;
    end
    an  = ((h + k - 1) * (w + k - 1)) & 4095;
    wn  = (k * k * oc) & 1023;
    bad = !(k == 1 || k == 3) || an > 2048 || wn > 512 || an == 0 || wn == 0;
    npe = (np == 0) ? 1 : np;
    if (bad) begin
      dt = 2;
    end else begin
      t = 2; abase = 0; wbase = 0;
      for (int p = 0; p < npe; p++) begin
        ai = 0; wi = 0;
        while (ai < an || wi < wn) begin
          stl = (t >= sf) && (t < sf + sl);
          if (!stl && ai < an) begin
            e_aen[t] = 1; e_aaddr[t] = 13'(abase + ai);
            e_av[t+LAT] = 1; e_aidx[t+LAT] = 11'(ai); e_pass[t+LAT] = 2'(p);
            ai++;
          end
          if (!stl && wi < wn) begin
            e_wen[t] = 1; e_waddr[t] = 11'(wbase + wi);
            e_wv[t+LAT] = 1; e_widx[t+LAT] = 9'(wi); e_pass[t+LAT] = 2'(p);
            wi++;
          end
          t++;
        end
        t = t + 1 + LAT;
        abase += an;
        wbase += wn;
      end
      dt = t;
    end
    for (int i = 1; i <= dt; i++) e_busy[i] = 1;
    e_done[dt] = 1;
    e_err[0] = ep;
    for (int i = 1; i < MAXT; i++) e_err[i] = bad && (i >= 2);
    e_len = dt + 4;
    if (ra >= 0) begin
      for (int i = ra; i < MAXT; i++) begin
        e_aen[i] = 0; e_wen[i] = 0; e_av[i] = 0; e_wv[i] = 0;
        e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0;
      end
      e_len = ra + 4;
    end
  endtask

  task automatic model_stats(output int dt, output int naen, output int nwen, output int last_av,
                             output int ndone, output int max_aaddr);
    dt = -1; naen = 0; nwen = 0; last_av = -1; ndone = 0; max_aaddr = -1;
    for (int i = 0; i < MAXT; i++) begin
      if (e_done[i]) begin dt = i; ndone++; end
      if (e_aen[i]) begin
        naen++;
        if (int'(e_aaddr[i]) > max_aaddr) max_aaddr = int'(e_aaddr[i]);
      end
      if (e_wen[i]) nwen++;
      if (e_av[i]) last_av = i;
    end
  endtask

  always @(negedge clk) begin
    int t;
    t = cyc - t0_cyc;
    if (chk_on && t >= 0 && t < MAXT) begin
      chk("act_en", t, 32'(act_sram_en), 32'(e_aen[t]));
      if (e_aen[t]) chk("act_sram_addr", t, 32'(act_sram_addr), 32'(e_aaddr[t]));
      chk("wgt_en", t, 32'(wgt_sram_en), 32'(e_wen[t]));
      if (e_wen[t]) chk("wgt_sram_addr", t, 32'(wgt_sram_addr), 32'(e_waddr[t]));
      chk("act_out_valid", t, 32'(act_out_valid), 32'(e_av[t]));
      if (e_av[t]) begin
        chk("act_out_addr", t, 32'(act_out_addr), 32'(e_aidx[t]));
        chk("act_out_data", t, 32'(act_out_data), 32'(a_fn(e_aaddr[t-LAT])));
        chk("pass_idx", t, 32'(pass_idx), 32'(e_pass[t]));
      end
      chk("wgt_out_valid", t, 32'(wgt_out_valid), 32'(e_wv[t]));
      if (e_wv[t]) begin
        chk("wgt_out_addr", t, 32'(wgt_out_addr), 32'(e_widx[t]));
        chk("wgt_out_data", t, 32'(wgt_out_data), 32'(w_fn(e_waddr[t-LAT])));
        chk("pass_idx_w", t, 32'(pass_idx), 32'(e_pass[t]));
      end
      chk("busy", t, 32'(busy), 32'(e_busy[t]));
      chk("done", t, 32'(done), 32'(e_done[t]));
      chk("cfg_err", t, 32'(cfg_err), 32'(e_err[t]));
    end
  end

  task automatic run(input int oc, h, w, k, np, sf, sl, ra, rs, input bit ep);
    build_model(oc, h, w, k, np, sf, sl, ra, ep);
    @(posedge clk); #1;
    cfg_oc = 6'(oc); cfg_img_h = 6'(h); cfg_img_w = 6'(w);
    cfg_k = 3'(k); cfg_num_pass = 2'(np);
    start = 1'b1; stall = 1'b0; reset = 1'b0;
    t0_cyc = cyc;
    chk_on = 1'b1;
    for (int t = 1; t < e_len; t++) begin
      @(posedge clk); #1;
      start = (t == rs);
      stall = (t >= sf) && (t < sf + sl);
      reset = (t == ra);
    end
    @(posedge clk); #1;
    chk_on = 1'b0; start = 1'b0; stall = 1'b0; reset = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_act_en"},   0, 32'(act_sram_en),   32'd0);
    chk({tag, "_act_addr"}, 0, 32'(act_sram_addr), 32'd0);
    chk({tag, "_wgt_en"},   0, 32'(wgt_sram_en),   32'd0);
    chk({tag, "_wgt_addr"}, 0, 32'(wgt_sram_addr), 32'd0);
    chk({tag, "_act_vld"},  0, 32'(act_out_valid), 32'd0);
    chk({tag, "_act_data"}, 0, 32'(act_out_data),  32'd0);
    chk({tag, "_act_oadr"}, 0, 32'(act_out_addr),  32'd0);
    chk({tag, "_wgt_vld"},  0, 32'(wgt_out_valid), 32'd0);
    chk({tag, "_wgt_data"}, 0, 32'(wgt_out_data),  32'd0);
    chk({tag, "_wgt_oadr"}, 0, 32'(wgt_out_addr),  32'd0);
    chk({tag, "_pass"},     0, 32'(pass_idx),      32'd0);
    chk({tag, "_busy"},     0, 32'(busy),          32'd0);
    chk({tag, "_done"},     0, 32'(done),          32'd0);
    chk({tag, "_cfg_err"},  0, 32'(cfg_err),       32'd0);
  endtask

  initial begin
    int dt, naen, nwen, lav, ndone, maxa;
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    cfg_oc = '0; cfg_img_h = '0; cfg_img_w = '0; cfg_k = '0; cfg_num_pass = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_zero("rst_hi");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_zero("rst_after");

    // K=3 4x4 OC=2, single pass
    run(2, 4, 4, 3, 1, -1, 0, -1, -1, 1'b0);
    model_stats(dt, naen, nwen, lav, ndone, maxa);
    chk("m1_done_t", 0, 32'(dt), 32'd40);
    chk("m1_act_reads", 0, 32'(naen), 32'd36);
    chk("m1_wgt_reads", 0, 32'(nwen), 32'd18);
    chk("m1_last_act_valid", 0, 32'(lav), 32'd38);

    // K=1 4x4 OC=4, three passes
    run(4, 4, 4, 1, 3, -1, 0, -1, -1, 1'b0);
    model_stats(dt, naen, nwen, lav, ndone, maxa);
    chk("m2_done_pulses", 0, 32'(ndone), 32'd1);
    chk("m2_act_reads", 0, 32'(naen), 32'd48);
    chk("m2_max_act_addr", 0, 32'(maxa), 32'd47);
    chk("m2_done_t", 0, 32'(dt), 32'd56);

    // Stall for 5 cycles when act index 10 is due
    run(2, 4, 4, 3, 1, 12, 5, -1, -1, 1'b0);
    model_stats(dt, naen, nwen, lav, ndone, maxa);
    chk("m3_done_t", 0, 32'(dt), 32'd45);

    // Illegal K, then a legal start clears cfg_err
    run(2, 4, 4, 2, 1, -1, 0, -1, -1, 1'b0);
    model_stats(dt, naen, nwen, lav, ndone, maxa);
    chk("m4_done_t", 0, 32'(dt), 32'd2);
    chk("m4_act_reads", 0, 32'(naen), 32'd0);
    run(2, 4, 4, 3, 1, -1, 0, -1, -1, 1'b1);

    // Reset mid-ISSUE at act index 20, then a normal run
    run(2, 4, 4, 3, 1, -1, 0, 22, -1, 1'b0);
    run(2, 4, 4, 3, 1, -1, 0, -1, -1, 1'b0);

    // Start re-pulsed during ISSUE is ignored
    run(2, 4, 4, 3, 1, -1, 0, -1, 10, 1'b0);

    // num_pass = 0 behaves as one pass
    run(1, 2, 2, 1, 0, -1, 0, -1, -1, 1'b0);

    // Weight-count boundary: 504 legal, 513 illegal; oversize act_n illegal
    run(56, 1, 1, 3, 1, -1, 0, -1, -1, 1'b0);
    run(57, 1, 1, 3, 1, -1, 0, -1, -1, 1'b0);
    run(1, 63, 63, 1, 1, -1, 0, -1, -1, 1'b1);
    run(1, 2, 2, 3, 2, -1, 0, -1, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/row_mem_load_sched.md
Name: row_mem_load_sched

Overview:
Sequencer that feeds the IA/weight row-memory distributor from the global activation and weight SRAMs.
- On start, latches the layer configuration and issues linear read streams to both SRAMs for one or more input-channel passes.
- Re-times the returned data to the SRAM read latency and presents each byte with its per-pass element index.
- Signals done once every pass has drained. Sits between the top-level layer controller and the row-memory distributor.

Parameters:
INPUT_BW, 8, data width of activation/weight bytes
ACT_PER_CORE, 11, per-pass activation index width
WEIGHT_PER_CORE, 9, per-pass weight index width
ACT_SRAM_AW, 13, global activation SRAM address width
WGT_SRAM_AW, 11, global weight SRAM address width
SRAM_RD_LAT, 1, SRAM read latency in cycles (1..4)

Ports:
clk  in  1  single clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
start  in  1  launch request, sampled only in IDLE
cfg_oc  in  6  output channels
cfg_img_h  in  6  output image height
cfg_img_w  in  6  output image width
cfg_k  in  3  kernel size, legal values 1 or 3
cfg_num_pass  in  2  IC passes; 0 is treated as 1
stall  in  1  suppress new SRAM reads
act_sram_en  out  1  activation SRAM read enable
act_sram_addr  out  ACT_SRAM_AW  activation SRAM address
act_sram_rdata  in  INPUT_BW  activation read data, valid SRAM_RD_LAT after en
wgt_sram_en  out  1  weight SRAM read enable
wgt_sram_addr  out  WGT_SRAM_AW  weight SRAM address
wgt_sram_rdata  in  INPUT_BW  weight read data
act_out_valid  out  1  activation byte valid
act_out_data  out  INPUT_BW  activation byte, signed
act_out_addr  out  ACT_PER_CORE  per-pass activation index
wgt_out_valid  out  1  weight byte valid
wgt_out_data  out  INPUT_BW  weight byte, signed
wgt_out_addr  out  WEIGHT_PER_CORE  per-pass weight index
pass_idx  out  2  current pass number
busy  out  1  high from start acceptance until done
done  out  1  one-cycle completion pulse
cfg_err  out  1  illegal config flag, held until next accepted start

Behaviour:
- Reset: one clock, synchronous, active-high. While reset is high and on the cycle after, all outputs are 0 and state is IDLE.
- Reset mid-operation: aborts immediately. In-flight reads are discarded, no valid and no done are issued.
- Start while busy is ignored.
- Derived counts, computed at latch time and held constant for the whole run:
  - act_n = (H+K-1)*(W+K-1), computed in 12 bits.
  - wgt_n = K*K*OC, computed in 10 bits.
- Illegal config raises cfg_err. Illegal means any of: K not in {1,3}; act_n > 2^ACT_PER_CORE; wgt_n > 2^WEIGHT_PER_CORE; act_n or wgt_n equal to 0.
- FSM: IDLE -> LATCH -> ISSUE -> DRAIN -> (ISSUE for the next pass | DONE) -> IDLE.
  - IDLE: on start, latch cfg_*, clear cfg_err, set busy.
  - LATCH: compute act_n and wgt_n; go to DONE if the config is illegal, else to ISSUE with pass_idx = 0 and both bases = 0.
  - ISSUE: each cycle with stall = 0, each stream whose index < its n asserts en with addr = base + index, then increments its index.
    - The two streams run independently; the shorter stream simply goes quiet when finished.
    - stall = 1 deasserts both ens. Indices hold.
    - Leave ISSUE once both indices reach n.
  - DRAIN: wait SRAM_RD_LAT cycles.
    - If pass_idx + 1 < num_pass: act base += act_n, wgt base += wgt_n, indices cleared, pass_idx++, return to ISSUE.
    - Else go to DONE.
  - DONE: done = 1 for one cycle, busy cleared, go to IDLE.
- Output timing: *_out_valid, *_out_addr and pass_idx are the en, index and pass of the read issued exactly SRAM_RD_LAT cycles earlier. *_out_data is rdata passed through combinationally.
- In-flight reads still deliver during stall; there is no output backpressure.
- Address arithmetic wraps modulo 2^AW. This is not an error.

Optional Feature:
LOAD_PERF_CNT_EN.
- Defined: adds two outputs.
  - perf_busy_cycles, 16 bits: counts cycles with busy = 1.
  - perf_stall_cycles, 16 bits: counts cycles in ISSUE with stall = 1.
  - Both saturate at 0xFFFF, clear on accepted start, and hold after done.
- Undefined: neither port nor the counters exist.

Decomposition:
- Shared package npu_load_pkg holds:
  - the FSM state encoding;
  - the legal-K constants (K1 = 1, K3 = 3);
  - the max-latency constant 4.
- One sub-module, rd_lat_pipe: a parameterised SRAM_RD_LAT-deep shift register carrying valid, index and pass. Instantiated once per stream.

Test Plan:
1. K=3, H=W=4, OC=2, num_pass=1, LAT=1, start at cycle 0: 36 act reads (addr 0..35, cycles 2..37) and 18 wgt reads; last act_out_valid at cycle 38, done at cycle 40, act_out_addr runs 0..35 in order.
2. K=1, H=W=4, OC=4, num_pass=3: act bases 0/16/32 and wgt bases 0/4/8; pass_idx steps 0/1/2; act_out_addr restarts at 0 each pass; exactly one done pulse.
3. Config 1 with stall held high for 5 cycles at act index 10: no ens during the stall, addresses continue at 10, outputs remain contiguous, done 5 cycles later than in scenario 1.
4. cfg_k=2 -> cfg_err = 1, zero ens, done 2 cycles after start, busy deasserted; a second start with K=3 clears cfg_err.
5. Reset asserted for 1 cycle at act index 20 in ISSUE -> all outputs 0 the next cycle, no valid or done afterwards, new start runs normally.
6. Start pulsed again during ISSUE -> ignored; counts, bases and done timing identical to scenario 1.
